bit_ram_rmw: RTL and testbench

Parametrised single-port bit memory for the IL processor's bit operand space, successor to the single-bit RAM. Adds configurable depth and atomic bit operations (set, clear, toggle, test-and-set style old-value return). Adds a change flag for edge-triggered instructions and a hardware clear-all sweep, since the storage array cannot be cleared asynchronously. Sits between the operand decode stage and the bit-operand bus; one operation accepted per clock.

---
 rtl/bit_ram_rmw_pkg.sv | 28 ++
 rtl/bit_ram_rmw_if.sv | 19 +
 rtl/bit_ram_clr_seq.sv | 56 +++++
 rtl/bit_ram_rmw.sv | 71 +++++++
 tb/tb_bit_ram_rmw.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/bit_ram_rmw_pkg.sv
// Shared op codes, default geometry and response type for the bit-operand RAM.
package bit_ram_rmw_pkg;
  localparam int BRAM_OP_W        = 3;
  localparam int BIT_RAM_DEPTH    = 256;
  localparam int BIT_RAM_ADDR_LEN = 8;

  typedef enum logic [BRAM_OP_W-1:0] {
    BRAM_OP_READ   = 3'd0,
    BRAM_OP_WRITE  = 3'd1,
    BRAM_OP_SET    = 3'd2,
    BRAM_OP_CLR    = 3'd3,
    BRAM_OP_TOG    = 3'd4,
    BRAM_OP_CLRALL = 3'd5
  } bram_op_e;

  typedef enum logic {ST_IDLE, ST_SWEEP} clr_state_e;

  typedef struct packed {
    logic dout;
    logic valid;
    logic changed;
    logic err;
  } bram_rsp_t;

  function automatic logic bram_op_legal(input logic [BRAM_OP_W-1:0] op);
    return op <= BRAM_OP_CLRALL;
  endfunction
endpackage

// File: rtl/bit_ram_rmw_if.sv
// Request/response bundle between operand decode (master) and the bit RAM (slave).
interface bit_ram_rmw_if
  import bit_ram_rmw_pkg::*;
#(
  parameter int ADDR_W = BIT_RAM_ADDR_LEN
);
  logic                 en;
  logic [BRAM_OP_W-1:0] op;
  logic [ADDR_W-1:0]    addr;
  logic                 din;
  logic                 dout;
  logic                 valid;
  logic                 changed;
  logic                 busy;
  logic                 err;

  modport master (output en, op, addr, din, input dout, valid, changed, busy, err);
  modport slave  (input en, op, addr, din, output dout, valid, changed, busy, err);
endinterface

// File: rtl/bit_ram_clr_seq.sv
// Clear-all sweep sequencer: walks the array one bit per clock, holding busy meanwhile.
module bit_ram_clr_seq
  import bit_ram_rmw_pkg::*;
#(
  parameter int DEPTH        = BIT_RAM_DEPTH,
  parameter int ADDR_W       = BIT_RAM_ADDR_LEN,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  output logic              busy_o,
  output logic              clr_stb_o,
  output logic [ADDR_W-1:0] clr_addr_o
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Reset aborts any sweep; the counter restarts from 0 on release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLR_ON_RESET ? ST_SWEEP : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o     = (state_q == ST_SWEEP);
  assign clr_stb_o  = busy_o;
  assign clr_addr_o = cnt_q;
endmodule

// File: rtl/bit_ram_rmw.sv
// Bit-operand RAM with atomic read-modify-write ops, change flag and clear-all sweep.
module bit_ram_rmw
  import bit_ram_rmw_pkg::*;
#(
  parameter int DEPTH        = BIT_RAM_DEPTH,
  parameter int ADDR_W       = BIT_RAM_ADDR_LEN,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  bit_ram_rmw_if.slave  bus
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic              busy, clr_stb, sweep_start;
  logic [ADDR_W-1:0] clr_addr;
  logic              mem_q [DEPTH];
  logic              in_range, acc, is_wr, old_bit, new_bit;
  bram_rsp_t         rsp_q, rsp_d;

  bit_ram_clr_seq #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLR_ON_RESET(CLR_ON_RESET)
  ) u_clr_seq (
    .clk       (clk),
    .reset     (reset),
    .start_i   (sweep_start),
    .busy_o    (busy),
    .clr_stb_o (clr_stb),
    .clr_addr_o(clr_addr)
  );

  always_comb begin
    in_range = {1'b0, bus.addr} < DEPTH_L;
    old_bit  = in_range ? mem_q[bus.addr] : 1'b0;
    acc      = reset && bus.en && !busy && in_range && bram_op_legal(bus.op);
    new_bit  = old_bit;
    is_wr    = 1'b0;
    case (bus.op)
      BRAM_OP_WRITE: begin new_bit = bus.din;  is_wr = 1'b1; end
      BRAM_OP_SET:   begin new_bit = 1'b1;     is_wr = 1'b1; end
      BRAM_OP_CLR:   begin new_bit = 1'b0;     is_wr = 1'b1; end
      BRAM_OP_TOG:   begin new_bit = ~old_bit; is_wr = 1'b1; end
      default: ;
    endcase
    sweep_start   = acc && (bus.op == BRAM_OP_CLRALL);
    rsp_d.valid   = acc && (bus.op != BRAM_OP_CLRALL);
    rsp_d.changed = acc && is_wr && (old_bit != new_bit);
    rsp_d.err     = bus.en && !acc;
    // Every reporting op returns the pre-op bit; otherwise dout holds.
    rsp_d.dout    = rsp_d.valid ? old_bit : rsp_q.dout;
  end

  // Array has no reset; sweep and accepted ops are mutually exclusive via busy.
  always_ff @(posedge clk) begin
    if (clr_stb)
      mem_q[clr_addr] <= 1'b0;
    else if (acc && is_wr)
      mem_q[bus.addr] <= new_bit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rsp_q <= '0;
    else        rsp_q <= rsp_d;
  end

  assign bus.dout    = rsp_q.dout;
  assign bus.valid   = rsp_q.valid;
  assign bus.changed = rsp_q.changed;
  assign bus.err     = rsp_q.err;
  assign bus.busy    = busy;
endmodule

// File: tb/tb_bit_ram_rmw.sv
// Directed scoreboard bench: DEPTH=256 and DEPTH=200 instances on one clock/reset.
module tb_bit_ram_rmw;
  import bit_ram_rmw_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bit_ram_rmw_if #(.ADDR_W(8)) ifa ();
  bit_ram_rmw_if #(.ADDR_W(8)) ifb ();

  bit_ram_rmw #(.DEPTH(256), .ADDR_W(8), .CLR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  bit_ram_rmw #(.DEPTH(200), .ADDR_W(8), .CLR_ON_RESET(1'b1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  int n_chk = 0;
  int n_err = 0;
  bram_rsp_t sb[$];
  logic ma [256];
  logic mb [200];
  logic da, db;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    ifa.en = 1'b0; ifa.op = '0; ifa.addr = '0; ifa.din = 1'b0;
    ifb.en = 1'b0; ifb.op = '0; ifb.addr = '0; ifb.din = 1'b0;
  endtask

  // Called at a negedge with both DUTs idle; checks the response one cycle later.
  task automatic op_step(input string tag, input bit sel, input bit en,
                         input logic [2:0] op, input logic [7:0] addr, input logic din);
    bram_rsp_t e, o;
    logic ok, old, nw, wr;
    int depth;
    depth = sel ? 200 : 256;
    ok    = en && (op <= 3'd5) && (int'(addr) < depth);
    old   = ok ? (sel ? mb[addr] : ma[addr]) : 1'b0;
    case (op)
      3'd1: nw = din;
      3'd2: nw = 1'b1;
      3'd3: nw = 1'b0;
      3'd4: nw = ~old;
      default: nw = old;
    endcase
    wr        = ok && (op >= 3'd1) && (op <= 3'd4);
    e.valid   = ok && (op != 3'd5);
    e.changed = wr && (old != nw);
    e.err     = en && !ok;
    e.dout    = e.valid ? old : (sel ? db : da);
    if (sel) begin
      if (wr) mb[addr] = nw;
      if (ok && op == 3'd5) foreach (mb[i]) mb[i] = 1'b0;
      db = e.dout;
      ifb.en = en; ifb.op = op; ifb.addr = addr; ifb.din = din;
    end else begin
      if (wr) ma[addr] = nw;
      if (ok && op == 3'd5) foreach (ma[i]) ma[i] = 1'b0;
      da = e.dout;
      ifa.en = en; ifa.op = op; ifa.addr = addr; ifa.din = din;
    end
    sb.push_back(e);
    @(negedge clk);
    idle_all();
    e = sb.pop_front();
    o = sel ? '{ifb.dout, ifb.valid, ifb.changed, ifb.err}
            : '{ifa.dout, ifa.valid, ifa.changed, ifa.err};
    chk({tag, ".dout"},    o.dout,    e.dout);
    chk({tag, ".valid"},   o.valid,   e.valid);
    chk({tag, ".changed"}, o.changed, e.changed);
    chk({tag, ".err"},     o.err,     e.err);
  endtask

  // Counts busy samples of both DUTs until both are idle (bounded).
  task automatic count_sweep(input string tag);
    int ca, cb;
    logic chg;
    ca = 0; cb = 0; chg = 1'b0;
    for (int i = 0; i < 1000 && (ifa.busy || ifb.busy); i++) begin
      ca += int'(ifa.busy);
      cb += int'(ifb.busy);
      chg |= ifa.changed | ifb.changed;
      @(negedge clk);
    end
    chk({tag, ".busy_a_cycles"}, ca, 256);
    chk({tag, ".busy_b_cycles"}, cb, 200);
    chk({tag, ".changed_in_sweep"}, chg, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ca;
    logic chg;
    foreach (ma[i]) ma[i] = 1'b0;
    foreach (mb[i]) mb[i] = 1'b0;
    da = 1'b0; db = 1'b0;
    idle_all();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.dout",    ifa.dout,    1'b0);
    chk("rst.valid",   ifa.valid,   1'b0);
    chk("rst.changed", ifa.changed, 1'b0);
    chk("rst.err",     ifa.err,     1'b0);
    chk("rst.busy_a",  ifa.busy,    1'b1);
    chk("rst.busy_b",  ifb.busy,    1'b1);
    reset = 1'b1;
    count_sweep("init");

    op_step("rd0",   0, 1, 3'd0, 8'd0,   1'b0);
    op_step("rd17",  0, 1, 3'd0, 8'd17,  1'b0);
    op_step("rd255", 0, 1, 3'd0, 8'd255, 1'b0);
    op_step("wr5",   0, 1, 3'd1, 8'd5,   1'b1);
    op_step("rd5",   0, 1, 3'd0, 8'd5,   1'b0);
    op_step("wr5same", 0, 1, 3'd1, 8'd5, 1'b1);
    op_step("set9a", 0, 1, 3'd2, 8'd9,   1'b0);
    op_step("set9b", 0, 1, 3'd2, 8'd9,   1'b0);
    op_step("tog9",  0, 1, 3'd4, 8'd9,   1'b0);
    op_step("rd9",   0, 1, 3'd0, 8'd9,   1'b0);
    op_step("rd5b",  0, 1, 3'd0, 8'd5,   1'b0);
    op_step("noen",  0, 0, 3'd2, 8'd9,   1'b0);
    op_step("clr5",  0, 1, 3'd3, 8'd5,   1'b0);
    op_step("tog5",  0, 1, 3'd4, 8'd5,   1'b0);

    op_step("b.set3",  1, 1, 3'd2, 8'd3,   1'b0);
    op_step("b.rd3",   1, 1, 3'd0, 8'd3,   1'b0);
    op_step("b.rd200", 1, 1, 3'd0, 8'd200, 1'b0);
    op_step("b.op7",   1, 1, 3'd7, 8'd3,   1'b0);
    op_step("b.op6",   1, 1, 3'd6, 8'd3,   1'b0);
    op_step("b.rd3b",  1, 1, 3'd0, 8'd3,   1'b0);
    op_step("b.wr255", 1, 1, 3'd1, 8'd255, 1'b0);
    op_step("b.rd199", 1, 1, 3'd0, 8'd199, 1'b0);

    op_step("set1", 0, 1, 3'd2, 8'd1, 1'b0);
    op_step("set2", 0, 1, 3'd2, 8'd2, 1'b0);
    op_step("set3", 0, 1, 3'd2, 8'd3, 1'b0);
    op_step("rd1",  0, 1, 3'd0, 8'd1, 1'b0);
    op_step("clrall", 0, 1, 3'd5, 8'd0, 1'b0);
    // Write request mid-sweep to an already-cleared address must be rejected.
    ca = 0; chg = 1'b0;
    for (int i = 0; i < 1000 && ifa.busy; i++) begin
      ca++;
      chg |= ifa.changed;
      if (i == 50) begin
        ifa.en = 1'b1; ifa.op = 3'd1; ifa.addr = 8'd5; ifa.din = 1'b1;
      end else if (i == 51) begin
        chk("busy_req.err",   ifa.err,   1'b1);
        chk("busy_req.valid", ifa.valid, 1'b0);
        chk("busy_req.dout",  ifa.dout,  da);
        idle_all();
      end
      @(negedge clk);
    end
    chk("clrall.busy_cycles", ca, 256);
    chk("clrall.changed",     chg, 1'b0);
    op_step("postclr.rd1", 0, 1, 3'd0, 8'd1, 1'b0);
    op_step("postclr.rd2", 0, 1, 3'd0, 8'd2, 1'b0);
    op_step("postclr.rd3", 0, 1, 3'd0, 8'd3, 1'b0);
    op_step("postclr.rd5", 0, 1, 3'd0, 8'd5, 1'b0);
    op_step("postclr.rd9", 0, 1, 3'd0, 8'd9, 1'b0);

    op_step("set7", 0, 1, 3'd2, 8'd7, 1'b0);
    op_step("rd7",  0, 1, 3'd0, 8'd7, 1'b0);
    op_step("clrall2", 0, 1, 3'd5, 8'd0, 1'b0);
    repeat (100) @(negedge clk);
    chk("midsweep.busy", ifa.busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("midrst.dout",   ifa.dout,  1'b0);
    chk("midrst.valid",  ifa.valid, 1'b0);
    chk("midrst.busy_a", ifa.busy,  1'b1);
    chk("midrst.dout_b", ifb.dout,  1'b0);
    da = 1'b0; db = 1'b0;
    foreach (mb[i]) mb[i] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    count_sweep("rerst");
    op_step("rerst.rd7",  0, 1, 3'd0, 8'd7, 1'b0);
    op_step("rerst.b.rd3", 1, 1, 3'd0, 8'd3, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
